// File: rtl/instr_stream_loader.sv
`default_nettype none
// ============================================================================
// instr_stream_loader: packs a byte stream into instruction-memory write windows,
// holding each write until the circular buffer has room ahead of the read pointer.
// Revision: 1.0
// ============================================================================
module instr_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WR_BYTES   = 8,
  parameter int LOG_WR     = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   read_pointer,
  output logic                    we,
  output logic [LOG_WR-1:0]       write_pointer_shift_minusone,
  output logic [8*WR_BYTES-1:0]   wr_data,
  output logic [ADDR_WIDTH-1:0]   write_pointer,
  output logic                    load_done,
  output logic [CNT_WIDTH-1:0]    bytes_loaded
);

  localparam int c_PACK_W = 8 * WR_BYTES;
  localparam logic [LOG_WR:0] c_CNT_LAST = (LOG_WR+1)'(WR_BYTES - 1);
  localparam logic [LOG_WR:0] c_CNT_ONE  = (LOG_WR+1)'(1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [LOG_WR:0]       r_cnt;
  logic [c_PACK_W-1:0]   r_pack;
  logic                  r_last_flag;

  logic [ADDR_WIDTH-1:0] w_used;
  logic [ADDR_WIDTH-1:0] w_free;
  logic [ADDR_WIDTH-1:0] w_cnt_ext;
  logic [ADDR_WIDTH-1:0] w_wp_next;
  logic                  w_space_ok;
  logic [LOG_WR-1:0]     w_byte_idx;
  logic [CNT_WIDTH:0]    w_bl_sum;

  assign w_used     = write_pointer - read_pointer;
  // Bitwise inverse of used is DEPTH-1-used: one byte always stays empty.
  assign w_free     = ~w_used;
  assign w_cnt_ext  = ADDR_WIDTH'(r_cnt);
  assign w_space_ok = (w_free >= w_cnt_ext);
  assign w_wp_next  = write_pointer + w_cnt_ext;
  assign w_byte_idx = r_cnt[LOG_WR-1:0];
  assign w_bl_sum   = {1'b0, bytes_loaded} + (CNT_WIDTH+1)'(r_cnt);

  assign s_ready = rst_n && (r_state == S_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                      <= S_FILL;
      r_cnt                        <= '0;
      r_pack                       <= '0;
      r_last_flag                  <= 1'b0;
      we                           <= 1'b0;
      write_pointer_shift_minusone <= '0;
      wr_data                      <= '0;
      write_pointer                <= '0;
      load_done                    <= 1'b0;
      bytes_loaded                 <= '0;
    end else begin
      we <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (s_valid) begin
            r_pack[{w_byte_idx, 3'b000} +: 8] <= s_data;
            r_cnt <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_CNT_LAST || s_last) begin
              r_state     <= S_FLUSH;
              r_last_flag <= s_last;
            end
          end
        end
        S_FLUSH: begin
          if (w_space_ok) begin
            we                           <= 1'b1;
            wr_data                      <= r_pack;
            write_pointer_shift_minusone <= LOG_WR'(r_cnt - c_CNT_ONE);
            write_pointer                <= w_wp_next;
            bytes_loaded                 <= w_bl_sum[CNT_WIDTH] ? '1 : w_bl_sum[CNT_WIDTH-1:0];
            r_cnt                        <= '0;
            r_pack                       <= '0;
            r_last_flag                  <= 1'b0;
            if (r_last_flag) begin
              r_state   <= S_DONE;
              load_done <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            r_state   <= S_FILL;
            load_done <= 1'b0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_loader.sv
`default_nettype none
// Directed bench for instr_stream_loader: byte stream in, scoreboarded write strobes out.
module tb_instr_stream_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int WR_BYTES   = 8;
  localparam int LOG_WR     = 3;
  localparam int CNT_WIDTH  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [7:0]            s_data = 8'h00;
  logic                  s_last = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] read_pointer = '0;
  logic                  we;
  logic [LOG_WR-1:0]     write_pointer_shift_minusone;
  logic [8*WR_BYTES-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] write_pointer;
  logic                  load_done;
  logic [CNT_WIDTH-1:0]  bytes_loaded;

  instr_stream_loader #(
    .ADDR_WIDTH(ADDR_WIDTH), .WR_BYTES(WR_BYTES), .LOG_WR(LOG_WR), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .start(start), .read_pointer(read_pointer), .we(we),
    .write_pointer_shift_minusone(write_pointer_shift_minusone), .wr_data(wr_data),
    .write_pointer(write_pointer), .load_done(load_done), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  shift;
    logic [7:0]  wp;
    logic [15:0] bl;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          writes = 0;
  logic [63:0] m_pack = '0;
  int          m_cnt = 0;
  logic [7:0]  m_wp = '0;
  int          m_bl = 0;
  bit          sb_en = 1'b1;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected window.
  always @(negedge clk) begin
    if (we) begin
      exp_t e;
      writes++;
      check("we_back_to_back", {63'd0, prev_we}, 64'd0);
      check("unexpected_we", 64'(sb.size() == 0), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_wr_data", wr_data, e.data);
        check("sb_shift", 64'(write_pointer_shift_minusone), 64'(e.shift));
        check("sb_write_pointer", 64'(write_pointer), 64'(e.wp));
        check("sb_bytes_loaded", 64'(bytes_loaded), 64'(e.bl));
      end
    end
    prev_we = we;
  end

  task automatic model_byte(input logic [7:0] d, input bit last);
    exp_t e;
    m_pack[8*m_cnt +: 8] = d;
    m_cnt++;
    if (m_cnt == WR_BYTES || last) begin
      m_wp   = m_wp + 8'(m_cnt);
      m_bl   = (m_bl + m_cnt > 65535) ? 65535 : m_bl + m_cnt;
      e.data = m_pack;
      e.shift = 3'(m_cnt - 1);
      e.wp   = m_wp;
      e.bl   = 16'(m_bl);
      sb.push_back(e);
      m_pack = '0;
      m_cnt  = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] d, input bit last);
    int guard = 0;
    if (sb_en) model_byte(d, last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_shift", 64'(write_pointer_shift_minusone), 64'd0);
    check("rst_write_pointer", 64'(write_pointer), 64'd0);
    check("rst_load_done", {63'd0, load_done}, 64'd0);
    check("rst_bytes_loaded", 64'(bytes_loaded), 64'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    m_pack = '0; m_cnt = 0; m_wp = '0; m_bl = 0;
    sb.delete();
    #1;
    check("rst_release_ready", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic fill_to_248();
    for (int i = 0; i < 248; i++) send(8'(i), 1'b0);
    drain();
    check("fill_wp_248", 64'(write_pointer), 64'd248);
  endtask

  initial begin
    int w0;

    // Reset with s_valid held high
    do_reset();

    // Full window, back-to-back
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("full_ready_low", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    check("full_we", {63'd0, we}, 64'd1);
    check("full_ready_back", {63'd0, s_ready}, 64'd1);
    check("full_data", wr_data, 64'h0807060504030201);
    check("full_shift", 64'(write_pointer_shift_minusone), 64'd7);
    check("full_wp", 64'(write_pointer), 64'd8);
    check("full_bl", 64'(bytes_loaded), 64'd8);
    @(negedge clk);
    check("full_we_single", {63'd0, we}, 64'd0);

    // Partial last window, then restart
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    @(negedge clk);
    check("part_we", {63'd0, we}, 64'd1);
    check("part_data", wr_data, 64'h0000000000CCBBAA);
    check("part_shift", 64'(write_pointer_shift_minusone), 64'd2);
    check("part_load_done", {63'd0, load_done}, 64'd1);
    check("part_ready_done", {63'd0, s_ready}, 64'd0);
    repeat (2) @(negedge clk);
    check("done_hold", {63'd0, load_done}, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", {63'd0, s_ready}, 64'd1);
    check("start_load_done", {63'd0, load_done}, 64'd0);
    check("start_wp_kept", 64'(write_pointer), 64'd11);

    // Gapped stream of 16 bytes
    w0 = writes;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'h30 + 8'(i), 1'b0);
    end
    drain();
    check("gap_writes", 64'(writes - w0), 64'd2);
    check("gap_wp", 64'(write_pointer), 64'd27);

    // Backpressure and wrap
    do_reset();
    fill_to_248();
    for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("bp_we_low", {63'd0, we}, 64'd0);
      check("bp_ready_low", {63'd0, s_ready}, 64'd0);
      @(negedge clk);
    end
    read_pointer = 8'd8;
    @(negedge clk);
    check("bp_we", {63'd0, we}, 64'd1);
    check("bp_wrap_wp", 64'(write_pointer), 64'd0);
    check("bp_bl", 64'(bytes_loaded), 64'd256);
    drain();
    read_pointer = 8'd0;

    // Reset while stalled in FLUSH
    do_reset();
    fill_to_248();
    sb_en = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hF0 + 8'(i), 1'b0);
    @(negedge clk);
    check("rf_stalled", {63'd0, s_ready}, 64'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rf_we_in_reset", {63'd0, we}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rf_wp", 64'(write_pointer), 64'd0);
    check("rf_bl", 64'(bytes_loaded), 64'd0);
    check("rf_ready", {63'd0, s_ready}, 64'd1);
    sb_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
